// File: rtl/adder_pkg.sv
// Types and helpers shared by the adder family (adder_rca, adder_pipe) and their benches.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int ADDER_DEFAULT_N = 32;
    localparam int ADDER_DEFAULT_S = 4;

    function automatic int chunk_w(input int n, input int s);
        return n / s;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe; the slave side is the adder itself.
interface adder_pipe_if #(parameter int N = 32);
    import adder_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    op_t          op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         co;
    logic         ov;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, s, co, ov
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, s, co, ov
    );

endinterface

// File: rtl/adder_rca.sv
// Combinational ripple-carry adder; used as the per-chunk adder inside each adder_pipe stage.
module adder_rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);

    logic carry;

    always_comb begin
        s_o   = '0;
        carry = ci_i;
        for (int i = 0; i < N; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        co_o = carry;
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined N-bit adder/subtractor, one W=N/S chunk per stage, valid/ready on both sides.
// Define ADDER_PIPE_SATURATE_EN to clamp the result to signed max/min on overflow.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int N = ADDER_DEFAULT_N,
    parameter int S = ADDER_DEFAULT_S
) (
    input  logic        clk,
    input  logic        rstn,
    adder_pipe_if.slave bus
);

    localparam int W = chunk_w(N, S);

    if (S < 1 || S > N || (N % S) != 0) begin : gBadParams
        $fatal(1, "adder_pipe: N must be a multiple of S with 1 <= S <= N");
    end

    logic         en;
    logic         outValid;
    logic [N-1:0] bAdj;
    logic [N-1:0] sumRaw;

    // A stalled output freezes every stage, so nothing in flight can be overwritten.
    assign en          = bus.out_ready | ~outValid;
    assign bus.in_ready = en;
    assign bAdj        = (bus.op == OP_SUB) ? ~bus.b : bus.b;

    for (genvar k = 0; k < S; k++) begin : gStage
        localparam int UP = N - (k + 1) * W;

        logic [W-1:0]         opA;
        logic [W-1:0]         opB;
        logic [W-1:0]         sumChunk;
        logic                 cin;
        logic                 cout;
        logic                 valid_d;
        logic [(k+1)*W-1:0]   sum_d;
        logic                 valid_q;
        logic                 carry_q;
        logic [(k+1)*W-1:0]   sum_q;

        if (k == 0) begin : gFirst
            assign opA     = bus.a[W-1:0];
            assign opB     = bAdj[W-1:0];
            assign cin     = (bus.op == OP_SUB);
            assign valid_d = bus.in_valid;
            assign sum_d   = sumChunk;
        end else begin : gNext
            assign opA     = gStage[k-1].gSkew.skewA_q[W-1:0];
            assign opB     = gStage[k-1].gSkew.skewB_q[W-1:0];
            assign cin     = gStage[k-1].carry_q;
            assign valid_d = gStage[k-1].valid_q;
            assign sum_d   = {sumChunk, gStage[k-1].sum_q};
        end

        adder_rca #(.N(W)) uRca (
            .a_i  (opA),
            .b_i  (opB),
            .ci_i (cin),
            .s_o  (sumChunk),
            .co_o (cout)
        );

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= valid_d;
                carry_q <= cout;
                sum_q   <= sum_d;
            end
        end

        // Operand chunks not yet consumed travel alongside the partial sum.
        if (UP > 0) begin : gSkew
            logic [UP-1:0] skewA_d;
            logic [UP-1:0] skewB_d;
            logic [UP-1:0] skewA_q;
            logic [UP-1:0] skewB_q;

            if (k == 0) begin : gSrc
                assign skewA_d = bus.a[N-1:W];
                assign skewB_d = bAdj[N-1:W];
            end else begin : gSrc
                assign skewA_d = gStage[k-1].gSkew.skewA_q[UP+W-1:W];
                assign skewB_d = gStage[k-1].gSkew.skewB_q[UP+W-1:W];
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    skewA_q <= '0;
                    skewB_q <= '0;
                end else if (en) begin
                    skewA_q <= skewA_d;
                    skewB_q <= skewB_d;
                end
            end
        end

        if (k == S - 1) begin : gLast
            logic ov_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    ov_q <= 1'b0;
                end else if (en) begin
                    ov_q <= (opA[W-1] == opB[W-1]) & (sumChunk[W-1] != opA[W-1]);
                end
            end
        end
    end

    assign outValid      = gStage[S-1].valid_q;
    assign sumRaw        = gStage[S-1].sum_q;
    assign bus.out_valid = outValid;
    assign bus.co        = gStage[S-1].carry_q;
    assign bus.ov        = gStage[S-1].gLast.ov_q;

`ifdef ADDER_PIPE_SATURATE_EN
    // On overflow the raw sign bit is the inverse of the true sign, so it picks the rail.
    always_comb begin
        bus.s = sumRaw;
        if (bus.ov) begin
            bus.s = sumRaw[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
        end
    end
`else
    assign bus.s = sumRaw;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: corner cases, randomized traffic against a queue model,
// backpressure, mid-flight reset and a latency sweep over several stage counts.
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int N         = 32;
    localparam int S         = 4;
    localparam int SWEEP_NUM = 4;
    localparam int RAND_OPS  = 512;

    typedef struct packed {
        logic [N-1:0] s;
        logic         co;
        logic         ov;
    } result_t;

    logic    clk = 1'b0;
    logic    rstn;
    int      testsRun = 0;
    int      failures = 0;
    int      outCount = 0;
    result_t expQ[$];

    always #5 clk = ~clk;

    adder_pipe_if #(.N(N)) bus ();

    adder_pipe #(.N(N), .S(S)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic int sweepDepth(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    logic         swValid;
    logic         swOutValid [SWEEP_NUM];
    logic [N-1:0] swSum      [SWEEP_NUM];
    logic         swOv       [SWEEP_NUM];

    for (genvar i = 0; i < SWEEP_NUM; i++) begin : gSweep
        adder_pipe_if #(.N(N)) swBus ();
        assign swBus.in_valid  = swValid;
        assign swBus.a         = 32'h7FFF_FFFF;
        assign swBus.b         = 32'h0000_0001;
        assign swBus.op        = OP_ADD;
        assign swBus.out_ready = 1'b1;
        assign swOutValid[i]   = swBus.out_valid;
        assign swSum[i]        = swBus.s;
        assign swOv[i]         = swBus.ov;

        adder_pipe #(.N(N), .S(sweepDepth(i))) uDut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (swBus)
        );
    end

    // Reference: plain integer arithmetic on the operands, independent of chunking.
    function automatic result_t refModel(input logic [N-1:0] a, input logic [N-1:0] b, input op_t op);
        result_t    r;
        longint     sa, sb, sr, maxPos, minNeg;
        logic [N:0] wide;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        maxPos = (longint'(1) <<< (N - 1)) - 1;
        minNeg = -(longint'(1) <<< (N - 1));
        if (op == OP_SUB) begin
            sr   = sa - sb;
            r.s  = a - b;
            r.co = (a >= b);
        end else begin
            sr   = sa + sb;
            wide = {1'b0, a} + {1'b0, b};
            r.s  = wide[N-1:0];
            r.co = wide[N];
        end
        r.ov = (sr > maxPos) || (sr < minNeg);
`ifdef ADDER_PIPE_SATURATE_EN
        if (r.ov) r.s = (sr > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [N-1:0] a, input logic [N-1:0] b, input op_t op);
        bus.in_valid = valid;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
    endtask

    // Evaluate both handshakes away from the edge, then advance to just after the next edge.
    task automatic stepCycle(output bit accepted);
        result_t exp;
        @(negedge clk);
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) expQ.push_back(refModel(bus.a, bus.b, bus.op));
        if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp = expQ.pop_front();
                checkOutput("result_sum", bus.s, exp.s);
                checkOutput("result_co", bus.co, exp.co);
                checkOutput("result_ov", bus.ov, exp.ov);
                outCount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runDirected(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input op_t op,
                               input logic [N-1:0] expS, input logic expCo, input logic expOv, input int expLat);
        int lat;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, a, b, op);
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, '0, OP_ADD);
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_sum"}, bus.s, expS);
        checkOutput({tag, "_co"}, bus.co, expCo);
        checkOutput({tag, "_ov"}, bus.ov, expOv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        bit           acc;
        bit           stalled;
        int           sent;
        logic [N-1:0] heldS;
        logic [N-1:0] subExp;
        logic [N-1:0] ovfExp;

`ifdef ADDER_PIPE_SATURATE_EN
        subExp = 32'h8000_0000;
        ovfExp = 32'h7FFF_FFFF;
`else
        subExp = 32'h7FFF_FFFF;
        ovfExp = 32'h8000_0000;
`endif

        rstn          = 1'b0;
        swValid       = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, OP_ADD);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_sum", bus.s, 0);
        checkOutput("reset_co", bus.co, 0);
        checkOutput("reset_ov", bus.ov, 0);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        runDirected("add_ripple", 32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, S);
        runDirected("sub_ovf", 32'h8000_0000, 32'h0000_0001, OP_SUB, subExp, 1'b1, 1'b1, S);
        runDirected("sub_borrow", 32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, S);
        runDirected("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, ovfExp, 1'b0, 1'b1, S);

        // Randomized traffic with random backpressure.
        sent = 0;
        outCount = 0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (sent == RAND_OPS && expQ.size() == 0) break;
            if (!bus.in_valid && sent < RAND_OPS && $urandom_range(0, 3) != 0)
                applyStimulus(1'b1, $urandom, $urandom, op_t'($urandom_range(0, 1)));
            bus.out_ready = 1'($urandom_range(0, 1));
            stalled = bus.out_valid && !bus.out_ready;
            heldS   = bus.s;
            stepCycle(acc);
            if (acc) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            if (stalled) begin
                checkOutput("hold_out_valid", bus.out_valid, 1);
                checkOutput("hold_sum", bus.s, heldS);
            end
        end
        checkOutput("random_sent", sent, RAND_OPS);
        checkOutput("random_received", outCount, RAND_OPS);
        checkOutput("random_queue_empty", expQ.size(), 0);
        checkOutput("random_drained", bus.out_valid, 0);

        // Fill the pipeline against a blocked output, hold, then drain.
        bus.out_ready = 1'b0;
        for (int i = 0; i < S; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, op_t'($urandom_range(0, 1)));
            stepCycle(acc);
            checkOutput("fill_accept", acc, 1);
        end
        applyStimulus(1'b1, $urandom, $urandom, OP_ADD);
        heldS = bus.s;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_in_ready", bus.in_ready, 0);
            checkOutput("stall_out_valid", bus.out_valid, 1);
            checkOutput("stall_sum", bus.s, heldS);
            stepCycle(acc);
            checkOutput("stall_no_accept", acc, 0);
        end
        applyStimulus(1'b0, '0, '0, OP_ADD);
        bus.out_ready = 1'b1;
        for (int i = 0; i < S; i++) begin
            checkOutput("drain_out_valid", bus.out_valid, 1);
            stepCycle(acc);
        end
        checkOutput("drain_empty", bus.out_valid, 0);
        checkOutput("drain_queue_empty", expQ.size(), 0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, OP_ADD);
            stepCycle(acc);
        end
        applyStimulus(1'b0, '0, '0, OP_ADD);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("midreset_out_valid", bus.out_valid, 0);
        checkOutput("midreset_sum", bus.s, 0);
        expQ.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        runDirected("after_reset", 32'h1234_5678, 32'h0000_1111, OP_ADD, 32'h1234_6789, 1'b0, 1'b0, S);

        // Latency sweep across stage counts.
        swValid = 1'b1;
        @(posedge clk);
        #1;
        swValid = 1'b0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            for (int i = 0; i < SWEEP_NUM; i++) begin
                checkOutput($sformatf("sweep_s%0d_valid_c%0d", sweepDepth(i), cyc), swOutValid[i],
                            64'(cyc == sweepDepth(i)));
                if (cyc == sweepDepth(i)) begin
                    checkOutput($sformatf("sweep_s%0d_sum", sweepDepth(i)), swSum[i], ovfExp);
                    checkOutput($sformatf("sweep_s%0d_ov", sweepDepth(i)), swOv[i], 1);
                end
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
